alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined integer ALU for the Y86-64 execute path. Generalises the standalone 64-bit bitwise/arithmetic units.
- Supports the four OPq functions: addq, subq, andq, xorq.
- Uses a valid/ready handshake on both sides, so the execute stage can stall it.
- Owns the architectural condition-code register (ZF, SF, OF); this register is updated only when a flag-setting result is accepted downstream.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_comb.sv | 45 ++++
 rtl/alu_pipe.sv | 134 +++++++++++++
 tb/tb_alu_pipe.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the Y86-64 execute-path ALU.
//   FUN_*     : OPq function codes (Y86 ifun)
//   CC_*      : bit positions of ZF/SF/OF inside a 3-bit flag vector
//   CC_RESET  : architectural condition codes after reset (ZF=1)
package alu_pkg;

  localparam int unsigned FUN_ADD = 0;
  localparam int unsigned FUN_SUB = 1;
  localparam int unsigned FUN_AND = 2;
  localparam int unsigned FUN_XOR = 3;

  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/alu_comb.sv
// alu_comb: purely combinational WIDTH-bit OPq datapath.
//   fun   : function code (0=add, 1=sub, 2=and, 3=xor, others illegal)
//   a, b  : valA / valB, two's complement
//   res   : result (b+a, b-a, a&b, a^b); zero for an illegal code
//   flags : {ZF,SF,OF} of res; zero for an illegal code
//   err   : illegal function code
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned FUNW  = 4
) (
  input  logic [FUNW-1:0]  fun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic [2:0]       flags,
  output logic             err
);

  always_comb begin
    res   = '0;
    flags = '0;
    err   = 1'b0;
    case (fun)
      FUNW'(FUN_ADD): begin
        res          = b + a;
        flags[CC_OF] = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      FUNW'(FUN_SUB): begin
        // Y86 subtracts valA from valB
        res          = b - a;
        flags[CC_OF] = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != b[WIDTH-1]);
      end
      FUNW'(FUN_AND): res = a & b;
      FUNW'(FUN_XOR): res = a ^ b;
      default:        err = 1'b1;
    endcase
    if (!err) begin
      flags[CC_ZF] = (res == '0);
      flags[CC_SF] = res[WIDTH-1];
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined ALU owning the {ZF,SF,OF} register.
//   clk, rst            : rising-edge clock, async active-high reset
//   in_valid/in_ready   : operation handshake (fun, a, b, set_cc)
//   out_valid/out_ready : result handshake (res, flags, err)
//   cc                  : architectural condition codes, written only when a
//                         flag-setting, error-free result is accepted
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned FUNW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FUNW-1:0]  in_fun,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [2:0]       out_flags,
  output logic             out_err,
  output logic [2:0]       cc
);

  logic             s1_valid_q, s1_valid_d;
  logic [FUNW-1:0]  s1_fun_q, s1_fun_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_set_cc_q, s1_set_cc_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_res_q, s2_res_d;
  logic [2:0]       s2_flags_q, s2_flags_d;
  logic             s2_err_q, s2_err_d;
  logic             s2_set_cc_q, s2_set_cc_d;

  logic [2:0]       cc_q, cc_d;

  logic             s1_adv, in_xfer, out_xfer;
  logic [WIDTH-1:0] alu_res;
  logic [2:0]       alu_flags;
  logic             alu_err;

  alu_comb #(.WIDTH(WIDTH), .FUNW(FUNW)) u_alu (
    .fun   (s1_fun_q),
    .a     (s1_a_q),
    .b     (s1_b_q),
    .res   (alu_res),
    .flags (alu_flags),
    .err   (alu_err)
  );

  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = s2_valid_q && out_ready;

  assign out_valid = s2_valid_q;
  assign out_res   = s2_res_q;
  assign out_flags = s2_flags_q;
  assign out_err   = s2_err_q;
  assign cc        = cc_q;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_fun_d    = s1_fun_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_set_cc_d = s1_set_cc_q;
    if (in_xfer) begin
      s1_valid_d  = 1'b1;
      s1_fun_d    = in_fun;
      s1_a_d      = in_a;
      s1_b_d      = in_b;
      s1_set_cc_d = in_set_cc;
    end else if (s1_adv) begin
      s1_valid_d  = 1'b0;
    end

    s2_valid_d  = s2_valid_q;
    s2_res_d    = s2_res_q;
    s2_flags_d  = s2_flags_q;
    s2_err_d    = s2_err_q;
    s2_set_cc_d = s2_set_cc_q;
    if (s1_adv) begin
      s2_valid_d  = 1'b1;
      s2_res_d    = alu_res;
      s2_flags_d  = alu_flags;
      s2_err_d    = alu_err;
      s2_set_cc_d = s1_set_cc_q;
    end else if (out_xfer) begin
      s2_valid_d  = 1'b0;
    end

    // CC commits at retirement only, so a stalled result never leaks into cc
    cc_d = cc_q;
    if (out_xfer && s2_set_cc_q && !s2_err_q) begin
      cc_d = s2_flags_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_fun_q    <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_set_cc_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_res_q    <= '0;
      s2_flags_q  <= '0;
      s2_err_q    <= 1'b0;
      s2_set_cc_q <= 1'b0;
      cc_q        <= CC_RESET;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_fun_q    <= s1_fun_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_set_cc_q <= s1_set_cc_d;
      s2_valid_q  <= s2_valid_d;
      s2_res_q    <= s2_res_d;
      s2_flags_q  <= s2_flags_d;
      s2_err_q    <= s2_err_d;
      s2_set_cc_q <= s2_set_cc_d;
      cc_q        <= cc_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_set_cc, out_valid, out_ready, out_err;
  logic [3:0]  in_fun;
  logic [63:0] in_a, in_b, out_res;
  logic [2:0]  out_flags, cc;

  logic        v8, rdy8, setcc8, ov8, err8;
  logic [3:0]  fun8;
  logic [7:0]  a8, b8, res8;
  logic [2:0]  flags8, cc8;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned edges = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  alu_pipe #(.WIDTH(64), .FUNW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_fun(in_fun),
    .in_a(in_a), .in_b(in_b), .in_set_cc(in_set_cc),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_flags(out_flags), .out_err(out_err), .cc(cc)
  );

  alu_pipe #(.WIDTH(8), .FUNW(4)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(v8), .in_ready(rdy8), .in_fun(fun8),
    .in_a(a8), .in_b(b8), .in_set_cc(setcc8),
    .out_valid(ov8), .out_ready(1'b1), .out_res(res8),
    .out_flags(flags8), .out_err(err8), .cc(cc8)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference: true (unbounded) arithmetic, overflow = result not representable in 64 bits
  function automatic void ref_op(input logic [3:0] fun, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] r, output logic [2:0] f, output logic e);
    logic signed [65:0] wide;
    r = 64'd0; f = 3'b000; e = 1'b0; wide = '0;
    case (fun)
      4'd0: wide = $signed({{2{b[63]}}, b}) + $signed({{2{a[63]}}, a});
      4'd1: wide = $signed({{2{b[63]}}, b}) - $signed({{2{a[63]}}, a});
      4'd2: wide = {2'b00, a & b};
      4'd3: wide = {2'b00, a ^ b};
      default: e = 1'b1;
    endcase
    if (!e) begin
      r    = wide[63:0];
      f[2] = (r == 64'd0);
      f[1] = r[63];
      f[0] = (fun <= 4'd1) && (wide != $signed({{2{r[63]}}, r}));
    end
  endfunction

  typedef struct {
    logic [63:0] res;
    logic [2:0]  flags;
    logic        err;
    logic        set_cc;
    int unsigned acc_edge;
  } exp_t;

  exp_t        mq[$];
  logic [2:0]  cc_m = 3'b100;
  logic        hold_prev = 1'b0;
  logic [63:0] prev_res;
  logic [2:0]  prev_flags;
  logic        prev_err;

  // Compare process: checks outputs each negedge, then advances the model by
  // the transfers that the coming posedge will perform.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      cc_m = 3'b100;
      hold_prev = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_cc", cc, 3'b100);
    end else begin
      chk("out_valid", out_valid, (mq.size() > 0) && (mq[0].acc_edge < edges));
      chk("in_ready", in_ready, (mq.size() < 2) || out_ready);
      chk("cc", cc, cc_m);
      if (out_valid && mq.size() > 0) begin
        chk("res", out_res, mq[0].res);
        chk("flags", out_flags, mq[0].flags);
        chk("err", out_err, mq[0].err);
      end
      if (hold_prev) begin
        chk("hold_res", out_res, prev_res);
        chk("hold_flags", out_flags, prev_flags);
        chk("hold_err", out_err, prev_err);
      end
      hold_prev  = out_valid && !out_ready;
      prev_res   = out_res;
      prev_flags = out_flags;
      prev_err   = out_err;
      if (out_valid && out_ready && mq.size() > 0) begin
        if (mq[0].set_cc && !mq[0].err) cc_m = mq[0].flags;
        void'(mq.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_t x;
        ref_op(in_fun, in_a, in_b, x.res, x.flags, x.err);
        x.set_cc   = in_set_cc;
        x.acc_edge = edges + 1;
        mq.push_back(x);
      end
    end
  end

  task automatic send_op(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b, input logic s);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_fun = f; in_a = a; in_b = b; in_set_cc = s;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    chk("send_accept", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk("wait_out_valid", out_valid, 1);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acc, got;
    logic do_acc;
    rst = 1'b1; in_valid = 1'b0; in_fun = '0; in_a = '0; in_b = '0; in_set_cc = 1'b0; out_ready = 1'b1;
    v8 = 1'b0; fun8 = '0; a8 = '0; b8 = '0; setcc8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_res", out_res, 0);
    chk("reset_flags", out_flags, 0);
    chk("reset_err", out_err, 0);
    chk("reset_cc", cc, 3'b100);
    chk("reset_valid", out_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1);

    // xor 20^50
    send_op(4'd3, 64'd20, 64'd50, 1'b1);
    wait_out(lat);
    chk("xor_latency", lat, 2);
    chk("xor_res", out_res, 64'd38);
    chk("xor_flags", out_flags, 3'b000);
    @(negedge clk);
    chk("xor_cc", cc, 3'b000);

    // sub: b - a = 5 - 7
    send_op(4'd1, 64'd7, 64'd5, 1'b1);
    wait_out(lat);
    chk("sub_res", out_res, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_flags", out_flags, 3'b010);
    @(negedge clk);
    chk("sub_cc", cc, 3'b010);

    // add overflow, then and producing zero
    send_op(4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    wait_out(lat);
    chk("addov_res", out_res, 64'h8000_0000_0000_0000);
    chk("addov_flags", out_flags, 3'b011);
    @(negedge clk);
    chk("addov_cc", cc, 3'b011);
    send_op(4'd2, 64'hF0, 64'h0F, 1'b1);
    wait_out(lat);
    chk("and_res", out_res, 64'd0);
    chk("and_flags", out_flags, 3'b100);
    @(negedge clk);
    chk("and_cc", cc, 3'b100);

    // backpressure: 4 xor ops a=i, b=0 with consumer stalled at first
    @(posedge clk); #1;
    out_ready = 1'b0; acc = 0; got = 0;
    in_fun = 4'd3; in_a = 64'd0; in_b = 64'd0; in_set_cc = 1'b1; in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      do_acc = in_valid && in_ready;
      if (cyc == 5) begin
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_accepted", acc, 2);
        chk("bp_res_hold", out_res, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_cc_unchanged", cc, 3'b100);
      end
      if (out_valid && out_ready) begin
        chk("bp_order", out_res, got);
        got++;
      end
      @(posedge clk); #1;
      if (do_acc) begin
        acc++;
        if (acc == 4) in_valid = 1'b0;
        else in_a = 64'(acc);
      end
      if (cyc == 5) out_ready = 1'b1;
    end
    chk("bp_count", got, 4);
    @(negedge clk);
    chk("bp_cc", cc, 3'b000);

    // illegal function with set_cc, then add without set_cc
    send_op(4'd5, 64'd9, 64'd9, 1'b1);
    wait_out(lat);
    chk("ill_err", out_err, 1);
    chk("ill_res", out_res, 0);
    chk("ill_flags", out_flags, 0);
    @(negedge clk);
    chk("ill_cc", cc, 3'b000);
    send_op(4'd0, 64'd0, 64'd0, 1'b0);
    wait_out(lat);
    chk("nocc_flags", out_flags, 3'b100);
    @(negedge clk);
    chk("nocc_cc", cc, 3'b000);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_fun    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      in_a      = pick();
      in_b      = pick();
      in_set_cc = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);

    // async reset with two ops in flight
    send_op(4'd3, 64'd1, 64'd0, 1'b1);
    repeat (3) @(negedge clk);
    chk("pre_rst_cc", cc, 3'b000);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_op(4'd0, 64'd3, 64'd4, 1'b1);
    send_op(4'd1, 64'd3, 64'd4, 1'b1);
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_ready", in_ready, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_cc", cc, 3'b100);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_stale", out_valid, 0);
    end

    // 8-bit instance
    @(posedge clk); #1;
    v8 = 1'b1; fun8 = 4'd0; a8 = 8'h7F; b8 = 8'h01; setcc8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy8) break;
    end
    @(posedge clk); #1;
    v8 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov8) break;
    end
    chk("w8_valid", ov8, 1);
    chk("w8_res", res8, 8'h80);
    chk("w8_flags", flags8, 3'b011);
    chk("w8_err", err8, 0);
    @(negedge clk);
    chk("w8_cc", cc8, 3'b011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
